// File: rtl/ram_block_engine.sv
// Block-operation initiator for a single-port register-array RAM.
// Runs one FILL, forward COPY or 32-bit SUM per accepted start command.
module ram_block_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_dbg
);

    // Command handshake: start is a strobe honoured only in IDLE; busy rises the
    // cycle after acceptance and stays high through the single-cycle done pulse.
    // Any start seen while busy is dropped without side effects.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     cnt_inc;
    logic                more;

    logic                busy_d, done_d, wen_d;
    logic [DATA_W-1:0]   result_d, wdata_d;
    logic [ADDR_W-1:0]   addr_d;

    assign cnt_inc   = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    assign more      = (cnt_inc < len_q);
    assign state_dbg = state_q;

    // Next-state logic computes the values every output will hold in the next
    // state, so all mem_* pins come straight from flops.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        busy_d   = busy;
        done_d   = 1'b0;
        result_d = result;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        wen_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    src_d    = src_addr;
                    dst_d    = dst_addr;
                    len_d    = len;
                    pat_d    = pattern;
                    cnt_d    = '0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    if (len == '0 || op == OP_RSVD) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (op == OP_FILL) begin
                        state_d = WR;
                        wen_d   = 1'b1;
                        addr_d  = dst_addr;
                        wdata_d = pattern;
                    end else begin
                        state_d = RD;
                        addr_d  = src_addr;
                    end
                end
            end

            RD: begin
                if (op_q == OP_SUM) begin
                    result_d = result + mem_rdata;
                    cnt_d    = cnt_inc;
                    if (more) begin
                        addr_d = src_q + cnt_inc[ADDR_W-1:0];
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    wdata_d = mem_rdata;
                    state_d = WR;
                    wen_d   = 1'b1;
                    addr_d  = dst_q + cnt_q[ADDR_W-1:0];
                end
            end

            WR: begin
                cnt_d = cnt_inc;
                if (more) begin
                    if (op_q == OP_FILL) begin
                        wen_d   = 1'b1;
                        addr_d  = dst_q + cnt_inc[ADDR_W-1:0];
                        wdata_d = pat_q + DATA_W'(cnt_inc);
                    end else begin
                        state_d = RD;
                        addr_d  = src_q + cnt_inc[ADDR_W-1:0];
                    end
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_FILL;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            busy      <= busy_d;
            done      <= done_d;
            result    <= result_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wen   <= wen_d;
        end
    end

endmodule

// File: tb/tb_ram_block_engine.sv
// Bench for ram_block_engine: a RAM array, a per-cycle expected-trace
// scoreboard built from the operation rules, directed cases and random ops.
module tb_ram_block_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op_i;
    logic [7:0]  src_i, dst_i;
    logic [8:0]  len_i;
    logic [31:0] pat_i;
    logic        busy, done, mem_wen;
    logic [31:0] result, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [1:0]  dbg_state;

    logic [31:0] ram [256];
    logic [31:0] exp_ram [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    // {chk_addr, chk_wdata, busy, done, wen, addr[7:0], wdata[31:0]}
    logic [44:0] exp_q [$];
    logic [31:0] exp_result = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wen_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int acc_cyc = 0;
    logic mon_en = 1'b0;

    ram_block_engine #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op_i),
        .src_addr  (src_i),
        .dst_addr  (dst_i),
        .len       (len_i),
        .pattern   (pat_i),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_rdata (mem_rdata),
        .state_dbg (dbg_state)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        else if (pre_en) ram[pre_addr] <= pre_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [44:0] ent(input logic ca, input logic cw, input logic b,
                                        input logic dn, input logic w,
                                        input logic [7:0] a, input logic [31:0] wd);
        return {ca, cw, b, dn, w, a, wd};
    endfunction

    task automatic monitor_loop();
        logic [44:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("ctl", {29'd0, busy, done, mem_wen}, {29'd0, e[42:40]});
                    if (e[44]) chk("addr", {24'd0, mem_addr}, {24'd0, e[39:32]});
                    if (e[43]) chk("wdata", mem_wdata, e[31:0]);
                    if (e[41]) chk("result_done", result, exp_result);
                end else begin
                    chk("idle_ctl", {29'd0, busy, done, mem_wen}, 32'd0);
                    chk("idle_result", result, exp_result);
                end
                if (mem_wen) wen_cnt++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        exp_ram[a] = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Expected per-cycle trace and final RAM image for one command; keep
    // truncates the trace when a reset aborts the operation.
    task automatic build_model(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                               input int n, input logic [31:0] p, input int keep);
        logic [31:0] sum, v;
        logic [7:0]  a;
        sum = '0;
        if (n != 0 && o != 2'b11) begin
            for (int k = 0; k < n; k++) begin
                if (o == 2'b00) begin
                    a = d + 8'(k);
                    v = p + 32'(k);
                    if (exp_q.size() < keep) begin
                        exp_ram[a] = v;
                        exp_q.push_back(ent(1, 1, 1, 0, 1, a, v));
                    end
                end else if (o == 2'b01) begin
                    a = s + 8'(k);
                    v = exp_ram[a];
                    if (exp_q.size() < keep) exp_q.push_back(ent(1, 0, 1, 0, 0, a, 32'd0));
                    a = d + 8'(k);
                    if (exp_q.size() < keep) begin
                        exp_ram[a] = v;
                        exp_q.push_back(ent(1, 1, 1, 0, 1, a, v));
                    end
                end else begin
                    a = s + 8'(k);
                    sum = sum + exp_ram[a];
                    if (exp_q.size() < keep) exp_q.push_back(ent(1, 0, 1, 0, 0, a, 32'd0));
                end
            end
        end
        if (exp_q.size() < keep) begin
            exp_q.push_back(ent(0, 0, 1, 1, 0, 8'd0, 32'd0));
            exp_result = (o == 2'b10 && n != 0) ? sum : 32'd0;
        end else begin
            exp_result = '0;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                          input int n, input logic [31:0] p, input int inject,
                          input int abort_cyc, output int lat);
        int keep;
        @(negedge clk);
        op_i = o; src_i = s; dst_i = d; len_i = 9'(n); pat_i = p; start = 1'b1;
        @(posedge clk);
        keep = (abort_cyc > 0) ? abort_cyc - 1 : 1000000;
        build_model(o, s, d, n, p, keep);
        wen_cnt = 0; done_cnt = 0; done_cyc = -1;
        #1 start = 1'b0;
        acc_cyc = cyc;
        if (inject > 0) begin
            repeat (inject - 1) @(posedge clk);
            #1 start = 1'b1;
            op_i = 2'b10; src_i = 8'($urandom); dst_i = 8'($urandom);
            len_i = 9'($urandom_range(1, 256)); pat_i = $urandom;
            @(posedge clk);
            #1 start = 1'b0;
        end
        if (abort_cyc > 0) begin
            repeat (abort_cyc - 2) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_wen", {31'd0, mem_wen}, 32'd0);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
        for (int t = 0; t < 1200; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout op=%0d len=%0d pending=%0d", o, n, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        lat = (done_cyc >= 0) ? done_cyc - acc_cyc + 1 : -1;
    endtask

    task automatic check_image(input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) if (ram[k] !== exp_ram[k]) bad++;
        chk(nm, 32'(bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] old22;
        logic [1:0]  ro;
        int          rn;

        rst_n = 1'b0; start = 1'b0; op_i = '0; src_i = '0; dst_i = '0; len_i = '0; pat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wen", {31'd0, mem_wen}, 32'd0);
        rst_n = 1'b1;
        fork
            monitor_loop();
        join_none
        mon_en = 1'b1;

        for (int k = 0; k < 256; k++) preload(8'(k), $urandom);

        run_op(2'b00, 8'h00, 8'h10, 4, 32'h100, 0, 0, lat);
        chk("fill_lat", 32'(lat), 32'd5);
        chk("fill_wen_cycles", 32'(wen_cnt), 32'd4);
        chk("fill_w0", ram[8'h10], 32'h100);
        chk("fill_w3", ram[8'h13], 32'h103);
        check_image("fill_image");

        preload(8'hFE, 32'hA0A0_0001);
        preload(8'hFF, 32'hB0B0_0002);
        preload(8'h00, 32'hC0C0_0003);
        preload(8'h01, 32'hD0D0_0004);
        run_op(2'b01, 8'hFE, 8'h40, 4, 32'h0, 0, 0, lat);
        chk("copy_lat", 32'(lat), 32'd9);
        chk("copy_w0", ram[8'h40], 32'hA0A0_0001);
        chk("copy_w2", ram[8'h42], 32'hC0C0_0003);
        chk("copy_w3", ram[8'h43], 32'hD0D0_0004);
        check_image("copy_image");

        preload(8'h00, 32'hFFFF_FFFF);
        preload(8'h01, 32'h2);
        preload(8'h02, 32'h3);
        run_op(2'b10, 8'h00, 8'h77, 3, 32'h0, 0, 0, lat);
        chk("sum_lat", 32'(lat), 32'd4);
        chk("sum_result", result, 32'h4);
        repeat (5) @(negedge clk);
        chk("sum_hold", result, 32'h4);

        for (int o = 0; o < 4; o++) begin
            run_op(2'(o), 8'($urandom), 8'($urandom), 0, $urandom, 0, 0, lat);
            chk("len0_lat", 32'(lat), 32'd1);
            chk("len0_wen", 32'(wen_cnt), 32'd0);
            chk("len0_result", result, 32'd0);
        end
        run_op(2'b11, 8'h05, 8'h06, 7, 32'h1, 0, 0, lat);
        chk("rsvd_lat", 32'(lat), 32'd1);
        chk("rsvd_wen", 32'(wen_cnt), 32'd0);
        check_image("len0_image");

        run_op(2'b00, 8'h00, 8'h80, 8, 32'h0BAD_0000, 3, 0, lat);
        chk("busy_start_lat", 32'(lat), 32'd9);
        chk("busy_start_dones", 32'(done_cnt), 32'd1);
        chk("busy_start_wen", 32'(wen_cnt), 32'd8);
        check_image("busy_start_image");

        old22 = exp_ram[8'h22];
        run_op(2'b00, 8'h00, 8'h20, 8, 32'h5000, 0, 3, lat);
        chk("abort_w0", ram[8'h20], 32'h5000);
        chk("abort_w1", ram[8'h21], 32'h5001);
        chk("abort_w2_kept", ram[8'h22], old22);
        chk("abort_dones", 32'(done_cnt), 32'd0);
        check_image("abort_image");

        for (int r = 0; r < 40; r++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: rn = 0;
                1: rn = 256;
                default: rn = $urandom_range(1, 20);
            endcase
            run_op(ro, 8'($urandom), 8'($urandom), rn, $urandom, 0, 0, lat);
            if (rn == 0 || ro == 2'b11) chk("rand_lat", 32'(lat), 32'd1);
            else if (ro == 2'b01) chk("rand_lat", 32'(lat), 32'(2 * rn + 1));
            else chk("rand_lat", 32'(lat), 32'(rn + 1));
            check_image("rand_image");
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
